// File: rtl/tile_draw_pkg.sv
// ----------------------------------------------------------------------------
// tile_draw_pkg
// Shared definitions for the tile blitter: the draw FSM state encoding,
// default tile geometry, the log2 of the tile dimensions and the resulting
// tile ROM address width ({idx, row, col}).
// Build option: TILE_DRAW_TRANSPARENT_EN (used by tile_draw_engine).
// ----------------------------------------------------------------------------
package tile_draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLOT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int TILE_W_DEF = 8;
    localparam int TILE_H_DEF = 8;
    localparam int IDX_W_DEF  = 4;

    localparam int COL_W      = $clog2(TILE_W_DEF);
    localparam int ROW_W      = $clog2(TILE_H_DEF);
    localparam int ROM_ADDR_W = IDX_W_DEF + ROW_W + COL_W;

endpackage

// File: rtl/tile_draw_engine_pixel_counter.sv
// ----------------------------------------------------------------------------
// tile_pixel_counter
// Raster-order col/row walker for one tile. col advances first; when it
// wraps from TILE_W-1 to 0 the row advances.
// Ports:
//   Clock, Resetn   clock, synchronous active-low reset
//   clr_i           restart at col 0, row 0 (wins over en_i)
//   en_i            advance one pixel
//   col_o, row_o    current pixel position inside the tile
//   last_o          current pixel is the final one (col and row at max)
// ----------------------------------------------------------------------------
module tile_pixel_counter #(
    parameter int TILE_W = 8,
    parameter int TILE_H = 8,
    parameter int COL_W  = $clog2(TILE_W),
    parameter int ROW_W  = $clog2(TILE_H)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_carry;

    assign row_carry = (col_q == COL_W'(TILE_W - 1));
    assign last_o    = row_carry && (row_q == ROW_W'(TILE_H - 1));
    assign col_o     = col_q;
    assign row_o     = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            col_d = row_carry ? '0 : col_q + 1'b1;
            row_d = row_carry ? row_q + 1'b1 : row_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/tile_draw_engine.sv
// ----------------------------------------------------------------------------
// tile_draw_engine
// Tile blitter. A Start pulse in IDLE latches the tile origin and index; the
// engine then walks the tile in raster order, reads each colour from a
// synchronous tile ROM and emits it as an (x, y, colour, Plot) write, holding
// the write until the framebuffer raises PlotReady.
// Ports:
//   Clock, Resetn            clock, synchronous active-low reset
//   Start                    draw request, sampled only in IDLE
//   TileX, TileY, TileIdx    tile origin and tile number
//   RomAddr / RomData        {idx,row,col} ROM address; data one cycle later
//   PixX, PixY, PixColor     pixel write data, stable while Plot=1
//   Plot / PlotReady         pixel write valid / framebuffer accept
//   Busy                     high outside IDLE
//   Done                     one-cycle pulse when a tile completes
// Build option: TILE_DRAW_TRANSPARENT_EN -- pixels whose colour equals
//   TRANSP_COLOR are skipped (no Plot) at 2 cycles per pixel.
// ----------------------------------------------------------------------------
module tile_draw_engine
    import tile_draw_pkg::*;
#(
    parameter int TILE_W       = TILE_W_DEF,
    parameter int TILE_H       = TILE_H_DEF,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOR_W      = 3,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int TRANSP_COLOR = 0
) (
    input  logic                                              Clock,
    input  logic                                              Resetn,
    input  logic                                              Start,
    input  logic [X_W-1:0]                                    TileX,
    input  logic [Y_W-1:0]                                    TileY,
    input  logic [IDX_W-1:0]                                  TileIdx,
    output logic [IDX_W+$clog2(TILE_W)+$clog2(TILE_H)-1:0]    RomAddr,
    input  logic [COLOR_W-1:0]                                RomData,
    output logic [X_W-1:0]                                    PixX,
    output logic [Y_W-1:0]                                    PixY,
    output logic [COLOR_W-1:0]                                PixColor,
    output logic                                              Plot,
    input  logic                                              PlotReady,
    output logic                                              Busy,
    output logic                                              Done
);

    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);

`ifdef TILE_DRAW_TRANSPARENT_EN
    localparam bit TranspEn = 1'b1;
`else
    localparam bit TranspEn = 1'b0;
`endif

    state_e             state_q;
    logic [X_W-1:0]     tile_x_q;
    logic [Y_W-1:0]     tile_y_q;
    logic [IDX_W-1:0]   idx_q;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic [Y_W-1:0]     pix_y_q, pix_y_d;
    logic [COLOR_W-1:0] pix_c_q;
    logic               plot_q, busy_q, done_q;

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               last_pix;
    logic               cnt_clr, cnt_en, skip;

    tile_pixel_counter #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) u_counter (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .col_o  (col),
        .row_o  (row),
        .last_o (last_pix)
    );

    // Transparent pixels are detected on the ROM word seen in LATCH; with the
    // option disabled TranspEn is constant 0 and skip folds away.
    assign skip    = TranspEn && (RomData == COLOR_W'(TRANSP_COLOR));

    // The counter advances on the same edge that retires a pixel, either by
    // a completed write or by a transparent skip.
    assign cnt_clr = (state_q == S_IDLE) && Start;
    assign cnt_en  = ((state_q == S_PLOT) && PlotReady) ||
                     ((state_q == S_LATCH) && skip);

    // Coordinates wrap naturally at the screen width; no clipping.
    assign pix_x_d = tile_x_q + X_W'(col);
    assign pix_y_d = tile_y_q + Y_W'(row);

    assign RomAddr  = {idx_q, row, col};
    assign PixX     = pix_x_q;
    assign PixY     = pix_y_q;
    assign PixColor = pix_c_q;
    assign Plot     = plot_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            tile_x_q <= '0;
            tile_y_q <= '0;
            idx_q    <= '0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            pix_c_q  <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        tile_x_q <= TileX;
                        tile_y_q <= TileY;
                        idx_q    <= TileIdx;
                        busy_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    pix_c_q <= RomData;
                    pix_x_q <= pix_x_d;
                    pix_y_q <= pix_y_d;
                    if (skip) begin
                        if (last_pix) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else begin
                        plot_q  <= 1'b1;
                        state_q <= S_PLOT;
                    end
                end
                S_PLOT: begin
                    if (PlotReady) begin
                        plot_q <= 1'b0;
                        if (last_pix) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_draw_engine.sv
// ----------------------------------------------------------------------------
// tb_tile_draw_engine
// Directed-plus-random bench for tile_draw_engine. A tile ROM lives in the
// bench; the expected pixel stream is computed from the tile geometry with
// plain loops and modular arithmetic and compared against the writes seen on
// the Plot/PlotReady handshake.
// Honours TILE_DRAW_TRANSPARENT_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_tile_draw_engine;

    localparam int NPIX = 64;

`ifdef TILE_DRAW_TRANSPARENT_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] TileX = '0;
    logic [6:0] TileY = '0;
    logic [3:0] TileIdx = '0;
    logic [9:0] RomAddr;
    logic [2:0] RomData = '0;
    logic [7:0] PixX;
    logic [6:0] PixY;
    logic [2:0] PixColor;
    logic       Plot;
    logic       PlotReady = 1'b1;
    logic       Busy;
    logic       Done;

    tile_draw_engine dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Start     (Start),
        .TileX     (TileX),
        .TileY     (TileY),
        .TileIdx   (TileIdx),
        .RomAddr   (RomAddr),
        .RomData   (RomData),
        .PixX      (PixX),
        .PixY      (PixY),
        .PixColor  (PixColor),
        .Plot      (Plot),
        .PlotReady (PlotReady),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic [2:0] rom_mem [0:1023];
    pix_t       got_q[$];
    pix_t       exp_q[$];
    int         rise_q[$];
    int         ecount = 0;
    int         t0 = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         bad_idx = 0;
    logic [3:0] exp_idx = '0;
    logic       plot_prev = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge Clock) begin
        ecount  <= ecount + 1;
        RomData <= rom_mem[RomAddr];
    end

    // Observe writes, Plot rising edges, Done pulses and the ROM index field.
    always @(negedge Clock) begin
        if (Plot && PlotReady) got_q.push_back(pix_t'({PixX, PixY, PixColor}));
        if (Plot && !plot_prev) rise_q.push_back(ecount - t0 + 1);
        plot_prev <= Plot;
        if (Done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= ecount - t0 + 1;
        end
        if (Busy && (RomAddr[9:6] !== exp_idx)) bad_idx <= bad_idx + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference pixel stream: raster order, col fastest, coordinates mod 2^W.
    task automatic build_expected(input int tx, input int ty, input int idx, input bit transp);
        pix_t p;
        exp_q.delete();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                p.x = 8'((tx + c) % 256);
                p.y = 7'((ty + r) % 128);
                p.c = rom_mem[idx * 64 + r * 8 + c];
                if (!transp || p.c != 3'd0) exp_q.push_back(p);
            end
        end
    endtask

    int got_base, rise_base, done_base, idx_base;

    task automatic start_tile(input logic [7:0] x, input logic [6:0] y, input logic [3:0] idx);
        @(posedge Clock);
        #1;
        TileX = x; TileY = y; TileIdx = idx; Start = 1'b1;
        exp_idx   = idx;
        got_base  = got_q.size();
        rise_base = rise_q.size();
        done_base = done_cnt;
        idx_base  = bad_idx;
        @(posedge Clock);
        #1;
        t0 = ecount;
        Start = 1'b0;
        TileX = 8'($urandom); TileY = 7'($urandom); TileIdx = 4'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(posedge Clock);
            n++;
        end
        repeat (4) @(posedge Clock);
        chk({tag, "_done_count"}, done_cnt - done_base, 1);
        chk({tag, "_rom_idx_bad"}, bad_idx - idx_base, 0);
    endtask

    task automatic compare_stream(input string tag, input int limit);
        int ng = got_q.size() - got_base;
        int ne = (limit < exp_q.size()) ? limit : exp_q.size();
        int bad = 0;
        if (limit >= exp_q.size()) chk({tag, "_plot_count"}, ng, ne);
        for (int i = 0; i < ne && i < ng; i++) begin
            if (got_q[got_base + i] !== exp_q[i]) begin
                bad++;
                if (bad <= 4)
                    $display("  %s pixel %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", tag, i,
                             got_q[got_base+i].x, got_q[got_base+i].y, got_q[got_base+i].c,
                             exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        chk({tag, "_pixel_errors"}, bad, 0);
    endtask

    initial begin
        int bad_rise;
        logic [3:0] ia, ib, iw, ir;
        logic [7:0] tx;
        logic [6:0] ty;

        for (int i = 0; i < 1024; i++) rom_mem[i] = 3'($urandom);

        // ---- reset with Start held high ----
        Resetn = 1'b0; Start = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_plot", Plot, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_pixx", PixX, 0);
        chk("rst_pixy", PixY, 0);
        chk("rst_color", PixColor, 0);
        chk("rst_romaddr", RomAddr, 0);
        @(posedge Clock);
        #1;
        Start = 1'b0; Resetn = 1'b1;
        repeat (2) @(posedge Clock);
        chk("idle_busy", Busy, 0);

        // ---- basic draw ----
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rom_mem[3 * 64 + r * 8 + c] = 3'((r + c) % 7 + 1);
        build_expected(10, 20, 3, TR);
        start_tile(8'd10, 7'd20, 4'd3);
        wait_done("basic", 400);
        compare_stream("basic", NPIX);
        chk("basic_done_cycle", done_cyc, 193);
        bad_rise = 0;
        for (int n = 0; n < NPIX; n++)
            if (rise_base + n >= rise_q.size() || rise_q[rise_base + n] != 3 * n + 3) bad_rise++;
        chk("basic_plot_timing", bad_rise, 0);

        // ---- backpressure during pixel 2 ----
        ia = 4'($urandom_range(4, 15));
        for (int i = 0; i < 64; i++) if (rom_mem[ia * 64 + i] == 3'd0) rom_mem[ia * 64 + i] = 3'd1;
        build_expected(10, 20, ia, TR);
        start_tile(8'd10, 7'd20, ia);
        repeat (8) @(posedge Clock);
        #1;
        PlotReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            chk($sformatf("bp_plot_%0d", k), Plot, 1);
            chk($sformatf("bp_pixx_%0d", k), PixX, 12);
            chk($sformatf("bp_pixy_%0d", k), PixY, 20);
            chk($sformatf("bp_color_%0d", k), PixColor, rom_mem[ia * 64 + 2]);
            @(posedge Clock);
        end
        #1;
        PlotReady = 1'b1;
        wait_done("bp", 400);
        compare_stream("bp", NPIX);
        chk("bp_done_cycle", done_cyc, 198);

        // ---- coordinate wrap ----
        iw = 4'($urandom);
        for (int i = 0; i < 64; i++) if (rom_mem[iw * 64 + i] == 3'd0) rom_mem[iw * 64 + i] = 3'd7;
        build_expected(252, 126, iw, TR);
        start_tile(8'd252, 7'd126, iw);
        wait_done("wrap", 400);
        compare_stream("wrap", NPIX);
        chk("wrap_done_cycle", done_cyc, 193);

        // ---- Start while busy, then reset mid-draw ----
        ir = 4'($urandom);
        tx = 8'($urandom);
        ty = 7'($urandom);
        build_expected(tx, ty, ir, 1'b0);
        for (int i = 0; i < 64; i++) if (rom_mem[ir * 64 + i] == 3'd0) rom_mem[ir * 64 + i] = 3'd2;
        build_expected(tx, ty, ir, 1'b0);
        start_tile(tx, ty, ir);
        repeat (5) @(posedge Clock);
        #1;
        Start = 1'b1; TileX = tx + 8'd77; TileY = ty + 7'd33; TileIdx = ir + 4'd1;
        repeat (4) @(posedge Clock);
        #1;
        Start = 1'b0;
        begin
            int n = 0;
            while ((got_q.size() - got_base) < 10 && n < 300) begin
                @(posedge Clock);
                n++;
            end
        end
        chk("busy_ten_plots", ((got_q.size() - got_base) >= 10) ? 1 : 0, 1);
        compare_stream("busy_start", 10);
        #1;
        Resetn = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("midrst_plot", Plot, 0);
        chk("midrst_busy", Busy, 0);
        got_base = got_q.size();
        #1;
        Resetn = 1'b1;
        repeat (20) @(posedge Clock);
        chk("midrst_no_done", done_cnt - done_base, 0);
        chk("midrst_no_plots", got_q.size() - got_base, 0);

        ib = 4'($urandom);
        build_expected(0, 0, ib, TR);
        start_tile(8'd0, 7'd0, ib);
        wait_done("restart", 400);
        compare_stream("restart", NPIX);

        // ---- transparency key ----
        for (int i = 0; i < 64; i++) rom_mem[5 * 64 + i] = 3'd0;
        rom_mem[5 * 64 + 5] = 3'd6;
        build_expected(40, 30, 5, TR);
        start_tile(8'd40, 7'd30, 4'd5);
        wait_done("transp", 400);
        compare_stream("transp", NPIX);
        chk("transp_done_cycle", done_cyc, TR ? 130 : 193);
        if (TR) begin
            chk("transp_single_x", (got_q.size() > got_base) ? int'(got_q[got_base].x) : -1, 45);
            chk("transp_single_y", (got_q.size() > got_base) ? int'(got_q[got_base].y) : -1, 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
